// File: rtl/frame_fill_scheduler_if.sv
// Requester handshake and draw-frame write port of the fill scheduler.
// The scheduler takes the master modport; requesters and frame memory take slave.
interface frame_fill_scheduler_if #(
   parameter int NUM_REQ = 3,
   parameter int CMD_W   = 56
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*CMD_W-1:0] req_cmd;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       req_done;
   logic [14:0]              wr_addr;
   logic [23:0]              wr_data;
   logic                     wr_en;

   modport master (
      input  req_valid, req_cmd,
      output req_ready, req_done,
      output wr_addr, wr_data, wr_en
   );

   modport slave (
      output req_valid, req_cmd,
      input  req_ready, req_done,
      input  wr_addr, wr_data, wr_en
   );
endinterface

// File: rtl/frame_fill_scheduler.sv
// Round-robin rectangle fill scheduler driving the draw-frame write port.
// One pixel per permitted cycle, x inner / y outer, off-grid pixels clipped.
module frame_fill_scheduler #(
   parameter int NUM_REQ    = 3,
   parameter int GRID_W     = 16,
   parameter int GRID_H     = 12,
   parameter int BLANK_ONLY = 0,
   parameter int CMD_W      = 56
) (
   input  logic clk,
   input  logic rst,
   input  logic active_pixels,
   output logic busy,
   frame_fill_scheduler_if.master bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   state_t state, state_n;

   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      owner;
   logic [PW-1:0]      winner;
   logic               found;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] owner_oh;
   logic [CMD_W-1:0]   cmd;
   logic               empty;
   logic               permit;
   logic               in_grid;

   logic [23:0] color;
   logic [8:0]  x0_q;
   logic [8:0]  x_last;
   logic [8:0]  y_last;
   logic [8:0]  cur_x;
   logic [8:0]  cur_y;
   logic        drain;

   always_comb begin
      int j;
      found  = 1'b0;
      winner = '0;
      j      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && bus.req_valid[j]) begin
            found  = 1'b1;
            winner = PW'(j);
         end
      end
   end

   assign grant_oh = NUM_REQ'(1) << winner;
   assign owner_oh = NUM_REQ'(1) << owner;
   assign cmd      = bus.req_cmd[int'(winner)*CMD_W +: CMD_W];
   assign empty    = (cmd[23:16] == 8'd0) || (cmd[31:24] == 8'd0);
   assign permit   = (BLANK_ONLY == 0) || !active_pixels;
   assign in_grid  = (cur_x < 9'(GRID_W)) && (cur_y < 9'(GRID_H));

   assign bus.req_ready = (state == IDLE && found) ? grant_oh : '0;
   assign bus.req_done  = (state == DONE) ? owner_oh : '0;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (found) state_n = empty ? DONE : FILL;
         FILL: if (drain) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // drain holds FILL one extra cycle so the last registered write
   // is still inside FILL when it reaches the port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr      <= '0;
         owner       <= '0;
         color       <= '0;
         x0_q        <= '0;
         x_last      <= '0;
         y_last      <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         drain       <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  owner  <= winner;
                  color  <= cmd[55:32];
                  x0_q   <= {1'b0, cmd[7:0]};
                  cur_x  <= {1'b0, cmd[7:0]};
                  cur_y  <= {1'b0, cmd[15:8]};
                  x_last <= {1'b0, cmd[7:0]} + {1'b0, cmd[23:16]} - 9'd1;
                  y_last <= {1'b0, cmd[15:8]} + {1'b0, cmd[31:24]} - 9'd1;
                  drain  <= 1'b0;
               end
            end
            FILL: begin
               if (!drain && permit) begin
                  if (in_grid) begin
                     bus.wr_en   <= 1'b1;
                     bus.wr_addr <= 15'(18'(cur_x) * 18'(GRID_H) + 18'(cur_y));
                     bus.wr_data <= color;
                  end
                  if (cur_x == x_last) begin
                     cur_x <= x0_q;
                     if (cur_y == y_last) drain <= 1'b1;
                     else                 cur_y <= cur_y + 9'd1;
                  end else begin
                     cur_x <= cur_x + 9'd1;
                  end
               end
            end
            DONE: begin
               if (owner == PW'(NUM_REQ - 1)) rr_ptr <= '0;
               else                          rr_ptr <= owner + PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
